// File: rtl/average_pooling_engine.sv
// Average-pooling engine: scans the 1-bit canvas in POOL x POOL blocks and writes
// one saturated PIX_W-bit intensity per block into the pooled-image buffer.
module average_pooling_engine #(
    parameter int unsigned CANVAS_SIDE = 224,
    parameter int unsigned OUT_SIDE    = 28,
    parameter int unsigned POOL        = 8,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned OUT_ADDR_W  = 10,
    parameter int unsigned PIX_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  start,
    output logic                  done,
    output logic                  canvas_rd_en,
    output logic [ADDR_W-1:0]     canvas_rd_addr,
    input  logic                  canvas_rd_data,
    output logic                  pool_wr_en,
    output logic [OUT_ADDR_W-1:0] pool_wr_addr,
    output logic [PIX_W-1:0]      pool_wr_data
);

    localparam int unsigned BLK_W    = $clog2(OUT_SIDE);
    localparam int unsigned IN_W     = $clog2(POOL);
    localparam int unsigned AREA     = POOL * POOL;
    localparam int unsigned LOG_AREA = $clog2(AREA);
    localparam int unsigned SUM_W    = LOG_AREA + 1;
    localparam int unsigned SHIFT    = PIX_W - LOG_AREA;
    localparam int unsigned SCALE_W  = PIX_W + 1;

    localparam logic [SCALE_W-1:0] PIX_MAX  = SCALE_W'((32'd1 << PIX_W) - 32'd1);
    localparam logic [BLK_W-1:0]   BLK_LAST = BLK_W'(OUT_SIDE - 1);
    localparam logic [IN_W-1:0]    IN_LAST  = IN_W'(POOL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [BLK_W-1:0]        bx_q, bx_d, by_q, by_d;
    logic [IN_W-1:0]         ix_q, ix_d, iy_q, iy_d;
    logic [SUM_W-1:0]        acc_q, acc_d;
    logic                    rd_vld_q;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    wr_en_q, wr_en_d;
    logic [OUT_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]        wr_data_q, wr_data_d;
    logic                    done_q, done_d;

    logic [SUM_W-1:0]        acc_sum;
    logic [SCALE_W-1:0]      scaled;
    logic [PIX_W-1:0]        sat_pix;
    logic                    issue;
    logic [31:0]             x_d, y_d;

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d   = state_q;
        bx_d      = bx_q;
        by_d      = by_q;
        ix_d      = ix_q;
        iy_d      = iy_q;
        acc_d     = acc_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        issue     = 1'b0;

        // The pixel returned for last cycle's read joins the running block sum
        acc_sum = acc_q + SUM_W'(rd_vld_q & canvas_rd_data);
        scaled  = SCALE_W'(acc_sum) << SHIFT;
        sat_pix = (scaled > PIX_MAX) ? PIX_W'(PIX_MAX) : PIX_W'(scaled);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SCAN;
                    done_d  = 1'b0;
                    bx_d    = '0;
                    by_d    = '0;
                    ix_d    = '0;
                    iy_d    = '0;
                    acc_d   = '0;
                    issue   = 1'b1;
                end
            end
            S_SCAN: begin
                acc_d = acc_sum;
                if (ix_q == IN_LAST && iy_q == IN_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    issue = 1'b1;
                    if (ix_q == IN_LAST) begin
                        ix_d = '0;
                        iy_d = iy_q + IN_W'(1);
                    end else begin
                        ix_d = ix_q + IN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                acc_d     = acc_sum;
                state_d   = S_WRITE;
                wr_en_d   = 1'b1;
                wr_addr_d = OUT_ADDR_W'(32'(by_q) * OUT_SIDE + 32'(bx_q));
                wr_data_d = sat_pix;
            end
            S_WRITE: begin
                acc_d = '0;
                ix_d  = '0;
                iy_d  = '0;
                if (bx_q == BLK_LAST && by_q == BLK_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_SCAN;
                    issue   = 1'b1;
                    if (bx_q == BLK_LAST) begin
                        bx_d = '0;
                        by_d = by_q + BLK_W'(1);
                    end else begin
                        bx_d = bx_q + BLK_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        x_d = 32'(bx_d) * POOL + 32'(ix_d);
        y_d = 32'(by_d) * POOL + 32'(iy_d);
        if (issue) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(y_d * CANVAS_SIDE + x_d);
        end
    end

    // State and output registers; frozen while en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bx_q      <= '0;
            by_q      <= '0;
            ix_q      <= '0;
            iy_q      <= '0;
            acc_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            ix_q      <= ix_d;
            iy_q      <= iy_d;
            acc_q     <= acc_d;
            rd_vld_q  <= rd_en_q;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // Strobes are masked during a stall so a held request is reissued, not duplicated
    assign canvas_rd_en   = rd_en_q & en;
    assign canvas_rd_addr = rd_addr_q;
    assign pool_wr_en     = wr_en_q & en;
    assign pool_wr_addr   = wr_addr_q;
    assign pool_wr_data   = wr_data_q;
    assign done           = done_q;

endmodule

// File: tb/tb_average_pooling_engine.sv
// Directed bench for average_pooling_engine on a reduced 40x40 canvas (5x5 blocks of 8x8),
// so each full run is 25 * 66 = 1650 enabled edges.
module tb_average_pooling_engine;

    localparam int unsigned CS  = 40;
    localparam int unsigned OS  = 5;
    localparam int unsigned PL  = 8;
    localparam int unsigned AW  = 16;
    localparam int unsigned OAW = 10;
    localparam int unsigned PW  = 8;
    localparam int BLOCKS  = 25;
    localparam int RUN_CYC = 1650;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           en = 1'b1;
    logic           start = 1'b0;
    logic           done;
    logic           canvas_rd_en;
    logic [AW-1:0]  canvas_rd_addr;
    logic           canvas_rd_data = 1'b0;
    logic           pool_wr_en;
    logic [OAW-1:0] pool_wr_addr;
    logic [PW-1:0]  pool_wr_data;

    bit canvas [0:CS*CS-1];
    int cap_addr [0:63];
    int cap_data [0:63];
    int exp_pix  [0:BLOCKS-1];
    int wr_count = 0;
    int rd_count = 0;
    int strobe_viol = 0;
    int n_tests = 0;
    int n_fail = 0;

    average_pooling_engine #(
        .CANVAS_SIDE(CS), .OUT_SIDE(OS), .POOL(PL),
        .ADDR_W(AW), .OUT_ADDR_W(OAW), .PIX_W(PW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .done(done),
        .canvas_rd_en(canvas_rd_en), .canvas_rd_addr(canvas_rd_addr),
        .canvas_rd_data(canvas_rd_data),
        .pool_wr_en(pool_wr_en), .pool_wr_addr(pool_wr_addr), .pool_wr_data(pool_wr_data)
    );

    always #5 clk = ~clk;

    // Canvas memory: data appears the cycle after a read and holds until the next one
    always @(posedge clk) begin
        if (canvas_rd_en) canvas_rd_data <= canvas[canvas_rd_addr];
    end

    always @(negedge clk) begin
        if (pool_wr_en) begin
            if (wr_count < 64) begin
                cap_addr[wr_count] = int'(pool_wr_addr);
                cap_data[wr_count] = int'(pool_wr_data);
            end
            wr_count++;
        end
        if (canvas_rd_en) rd_count++;
        if (!en && (canvas_rd_en || pool_wr_en)) strobe_viol++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_pix(input int bx, input int by);
        int cnt = 0;
        for (int y = 0; y < int'(PL); y++)
            for (int x = 0; x < int'(PL); x++)
                if (canvas[(by * PL + y) * CS + bx * PL + x]) cnt++;
        return (cnt * 4 > 255) ? 255 : cnt * 4;
    endfunction

    task automatic fill(input bit v);
        for (int i = 0; i < int'(CS * CS); i++) canvas[i] = v;
    endtask

    task automatic run_and_check(input string name, input int stall_at, input int stall_len,
                                 input int extra_at);
        int done_cyc = -1;
        int limit = RUN_CYC + stall_len + 50;
        for (int b = 0; b < BLOCKS; b++) exp_pix[b] = model_pix(b % OS, b / OS);
        for (int i = 0; i < 64; i++) begin
            cap_addr[i] = -1;
            cap_data[i] = -1;
        end
        wr_count = 0;
        strobe_viol = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 0; c <= limit; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 0) check({name, "_done_drop"}, done, 0);
            if (c == extra_at) start = 1'b1;
            if (c == stall_at) en = 1'b0;
            if (c == stall_at + stall_len) en = 1'b1;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        en = 1'b1;
        check({name, "_done_edge"}, done_cyc, RUN_CYC + stall_len);
        repeat (5) @(negedge clk);
        check({name, "_done_hold"}, done, 1);
        check({name, "_wr_count"}, wr_count, BLOCKS);
        check({name, "_stall_strobes"}, strobe_viol, 0);
        for (int i = 0; i < BLOCKS; i++) begin
            check($sformatf("%s_addr%0d", name, i), cap_addr[i], i);
            check($sformatf("%s_data%0d", name, i), cap_data[i], exp_pix[i]);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_done"}, done, 0);
        check({name, "_rd_en"}, canvas_rd_en, 0);
        check({name, "_rd_addr"}, canvas_rd_addr, 0);
        check({name, "_wr_en"}, pool_wr_en, 0);
        check({name, "_wr_addr"}, pool_wr_addr, 0);
        check({name, "_wr_data"}, pool_wr_data, 0);
    endtask

    initial begin
        int rd_before;
        int wr_before;

        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("por");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_read", rd_count, 0);

        // Blank canvas
        fill(1'b0);
        run_and_check("blank", -1, 0, -1);
        check("blank_data_last", cap_data[BLOCKS-1], 0);

        // Full canvas saturates 64*4 to 255
        fill(1'b1);
        run_and_check("full", -1, 0, -1);
        check("full_data_0", cap_data[0], 255);
        check("full_data_last", cap_data[BLOCKS-1], 255);

        // One pixel at (8,0); 32 pixels in the last block
        fill(1'b0);
        canvas[0 * CS + 8] = 1'b1;
        for (int y = 32; y < 36; y++)
            for (int x = 32; x < 40; x++) canvas[y * CS + x] = 1'b1;
        run_and_check("sparse", -1, 0, -1);
        check("sparse_addr1", cap_data[1], 4);
        check("sparse_addr0", cap_data[0], 0);
        check("sparse_last", cap_data[24], 128);

        // Full canvas with a 100-cycle stall at cycle 30 of block 5
        fill(1'b1);
        run_and_check("stall", 5 * 66 + 30, 100, -1);

        // Graded canvas: block b holds (3*b)%65 set pixels; stray start at cycle 1000
        for (int y = 0; y < int'(CS); y++)
            for (int x = 0; x < int'(CS); x++)
                canvas[y * CS + x] = ((x % 8) + (y % 8) * 8) < (((x / 8) + 5 * (y / 8)) * 3) % 65;
        run_and_check("graded", -1, 0, 1000);
        check("graded_addr10", cap_data[10], 120);
        check("graded_addr21", cap_data[21], 252);
        check("graded_addr24", cap_data[24], 28);

        // Restart straight out of DONE
        run_and_check("restart", -1, 0, -1);

        // Reset in the middle of a run
        fill(1'b1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (800) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        rd_before = rd_count;
        wr_before = wr_count;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_no_read", rd_count, rd_before);
        check("midreset_no_write", wr_count, wr_before);
        check("midreset_done", done, 0);
        run_and_check("after_reset", -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
